// File: rtl/neander_seq_divider_if.sv
// Operand/result bundle between a requester and the sequential divider.
// The requester pulses start with operands; the divider reports busy/done and registered results.
interface neander_seq_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/neander_seq_divider.sv
// 8-bit unsigned restoring divider, one quotient bit per clock.
// Latency: 8 busy cycles then a 1-cycle done pulse; a zero divisor finishes in 1 cycle.
// Backpressure: none; start is ignored while busy and accepted again in the done cycle.
module neander_seq_divider (
    input  logic                        clk,
    input  logic                        reset,
    neander_seq_divider_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state;
    logic [2:0] step_cnt;
    logic [8:0] p;
    logic [7:0] q;
    logic [7:0] dvsr;

    logic [8:0] shifted;
    logic       fits;
    logic [8:0] p_next;
    logic [7:0] q_next;
    logic       unused_p_msb;

    // The partial remainder stays below the divisor, so p[8] is never needed on the next shift.
    assign unused_p_msb = p[8];

    always_comb begin
        shifted = {p[7:0], q[7]};
        fits    = (shifted >= {1'b0, dvsr});
        p_next  = shifted;
        q_next  = {q[6:0], 1'b0};
        if (fits) begin
            p_next = shifted - {1'b0, dvsr};
            q_next = {q[6:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            step_cnt        <= 3'd0;
            p               <= 9'd0;
            q               <= 8'd0;
            dvsr            <= 8'd0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= 8'd0;
            bus.remainder   <= 8'd0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    if (bus.start) begin
                        dvsr     <= bus.divisor;
                        step_cnt <= 3'd0;
                        p        <= 9'd0;
                        q        <= bus.dividend;
                        if (bus.divisor == 8'd0) begin
                            bus.quotient    <= 8'hFF;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    p        <= p_next;
                    q        <= q_next;
                    step_cnt <= step_cnt + 3'd1;
                    if (step_cnt == 3'd7) begin
                        bus.quotient    <= q_next;
                        bus.remainder   <= p_next[7:0];
                        bus.div_by_zero <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/neander_seq_divider.md
NEANDER_SEQ_DIVIDER -- requirements
Module: neander_seq_divider

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to begin a division; ignored unless the block is idle.
REQ-005 dividend  input  8  unsigned numerator; sampled only on the edge that accepts start.
REQ-006 divisor  input  8  unsigned denominator; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while iterations are in progress.
REQ-008 done  output  1  single-cycle pulse; the result registers were updated on the preceding edge.
REQ-009 quotient  output  8  registered quotient; feeds the ALU div_quotient input.
REQ-010 remainder  output  8  registered remainder; feeds the ALU div_remainder input.
REQ-011 div_by_zero  output  1  registered flag; feeds the ALU div_by_zero input.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted at the edge: operands latched internally, 3-bit step counter cleared.
REQ-014 On acceptance with divisor!=0, the next state SHALL be CALC.
REQ-015 On acceptance with divisor==0, the next state SHALL be DONE with no CALC cycles.
REQ-016 On a zero-divisor acceptance, the same edge SHALL load quotient=8'hFF, remainder=dividend and div_by_zero=1.
REQ-017 CALC SHALL perform one restoring step per edge on a 9-bit partial remainder P (initially 0) and shift register Q (initially dividend).
REQ-018 Each CALC step SHALL compute T={P[7:0],Q[7]}-{1'b0,divisor}: if T is non-negative, P=T and Q={Q[6:0],1}; otherwise P={P[7:0],Q[7]} and Q={Q[6:0],0}.
REQ-019 CALC SHALL run exactly 8 steps; on the 8th-step edge it SHALL load quotient=Q result, remainder=P[7:0] result and div_by_zero=0, and go to DONE.
REQ-020 Latency: with start accepted at edge k (divisor!=0), busy SHALL be high during the 8 cycles after edges k..k+7, and done high for the one cycle after edge k+8.
REQ-021 Latency: with start accepted at edge k (divisor==0), done SHALL be high for the one cycle after edge k, and busy SHALL remain low.
REQ-022 busy SHALL be 1 only in CALC; done SHALL be 1 only in DONE; busy and done SHALL never be high together.
REQ-023 With no start, DONE SHALL return to IDLE on the next edge.
REQ-024 A start in DONE SHALL be accepted exactly as in IDLE, enabling back-to-back divisions with no dead cycle.
REQ-025 start while in CALC SHALL be ignored; operands, counter and outputs are unaffected.
REQ-026 Changes on dividend/divisor after acceptance SHALL NOT affect the result in progress.
REQ-027 quotient, remainder and div_by_zero SHALL hold their last loaded values through IDLE and CALC until the next completion.
REQ-028 Results SHALL satisfy quotient*divisor+remainder==dividend with remainder<divisor for every divisor!=0.

Reset
REQ-029 Reset SHALL force state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; step counter and internal P/Q cleared.
REQ-030 Reset SHALL take priority over start at the same edge and SHALL abort any division in progress.
REQ-031 An aborted division SHALL NOT produce a done pulse or update any result output.

Verification
REQ-032 Normal divide: start, dividend=100, divisor=7 -> busy 8 cycles, then done 1 cycle, quotient=14, remainder=2, div_by_zero=0.
REQ-033 Boundary values:
- 255/1 -> quotient=255, remainder=0.
- 3/10 -> quotient=0, remainder=3.
- 255/255 -> quotient=1, remainder=0.
REQ-034 Divide by zero: start, dividend=5, divisor=0 -> done in the cycle after the start edge, busy never high, quotient=8'hFF, remainder=8'h05, div_by_zero=1.
REQ-035 Busy and back-to-back starts:
- Start 100/7, then in cycle 3 start 9/3 with changed operands -> ignored, result 14/2.
- A start held during the done cycle (200/16) -> accepted, result 12/8 after 8 more cycles.
REQ-036 Reset mid-operation: reset asserted in the 4th CALC cycle of 100/7 -> next cycle state IDLE, all outputs 0, no done pulse; a subsequent 50/6 returns quotient=8, remainder=2.
REQ-037 Exhaustive check: all 65536 dividend/divisor pairs against REQ-028, with the zero-divisor cases checked against REQ-016.
